// File: rtl/fetch_sequencer_if.sv
// Bundles the fetch sequencer's control inputs, instruction-memory bus and
// decode-stage handshake. master = sequencer side, slave = memory/decode/control side.
interface fetch_sequencer_if #(
  parameter int ADDR_W = 2,
  parameter int CNT_W  = 16
);
  logic              start;
  logic              step;
  logic              halt_req;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;

  logic [ADDR_W-1:0] im_addr;
  logic              im_cs;
  logic [31:0]       im_data;

  logic [31:0]       instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;

  logic              busy;
  logic [CNT_W-1:0]  fetch_count;

  modport master (
    input  start, step, halt_req, redirect, redirect_pc, im_data, instr_ready,
    output im_addr, im_cs, instr, instr_pc, instr_valid, busy, fetch_count
  );

  modport slave (
    output start, step, halt_req, redirect, redirect_pc, im_data, instr_ready,
    input  im_addr, im_cs, instr, instr_pc, instr_valid, busy, fetch_count
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Program counter and fetch controller for a combinational instruction memory,
// with a one-entry output register handed to decode over valid/ready.
module fetch_sequencer #(
  parameter int ADDR_W = 2,
  parameter int CNT_W  = 16
) (
  input  logic               clk,
  input  logic               reset,
  fetch_sequencer_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic slot_free;
  logic fire;

  assign slot_free = !valid_q || bus.instr_ready;
  assign fire      = (state_q != IDLE) && slot_free && !bus.redirect && !bus.halt_req;

  // NOTE: every next-state signal takes its hold value first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    cnt_d      = cnt_q;

    // Redirect flushes the held word even when decode is stalled.
    if (bus.redirect) begin
      pc_d    = bus.redirect_pc;
      valid_d = 1'b0;
    end else if (fire) begin
      instr_d    = bus.im_data;
      instr_pc_d = pc_q;
      valid_d    = 1'b1;
      pc_d       = pc_q + ADDR_W'(1);
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end else if (valid_q && bus.instr_ready) begin
      valid_d = 1'b0;
    end

    if (bus.halt_req) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start)     state_d = RUN;
          else if (bus.step) state_d = STEP;
        end
        RUN:  state_d = RUN;
        STEP: if (fire) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.im_addr     = pc_q;
  assign bus.im_cs       = fire;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = valid_q;
  assign bus.busy        = (state_q != IDLE) || valid_q;
  assign bus.fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a behavioural model predicts fetches,
// a negedge monitor compares outputs and pops accepted instructions.
module tb_fetch_sequencer;

  localparam int ADDR_W = 2;
  localparam int CNT_W  = 16;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fetch_sequencer_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();
  fetch_sequencer_if #(.ADDR_W(ADDR_W), .CNT_W(3))     sbus ();

  fetch_sequencer #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  fetch_sequencer #(.ADDR_W(ADDR_W), .CNT_W(3)) u_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (sbus.master)
  );

  logic [31:0] mem [DEPTH];
  assign bus.im_data  = mem[bus.im_addr];
  assign sbus.im_data = {30'h0, sbus.im_addr};

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode, pc, held-slot flag, saturating count, expected-word queue.
  typedef enum {M_IDLE, M_RUN, M_STEP} mode_t;
  typedef struct {
    logic [31:0] data;
    int          pc;
  } fetch_t;

  mode_t       m_mode  = M_IDLE;
  int          m_pc    = 0;
  bit          m_valid = 1'b0;
  int unsigned m_cnt   = 0;
  fetch_t      exp_q[$];

  function automatic bit m_fire();
    return (m_mode != M_IDLE) && (!m_valid || bus.instr_ready)
           && !bus.redirect && !bus.halt_req;
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_mode = M_IDLE; m_pc = 0; m_valid = 1'b0; m_cnt = 0;
        exp_q.delete();
      end else begin
        bit f;
        f = m_fire();
        if (bus.redirect) begin
          m_pc = int'(bus.redirect_pc);
          m_valid = 1'b0;
          exp_q.delete();
        end else if (f) begin
          fetch_t e;
          e.data = mem[m_pc];
          e.pc   = m_pc;
          exp_q.push_back(e);
          m_valid = 1'b1;
          m_pc = (m_pc + 1) % DEPTH;
          if (m_cnt < 65535) m_cnt++;
        end else if (m_valid && bus.instr_ready) begin
          m_valid = 1'b0;
        end
        if (bus.halt_req)                           m_mode = M_IDLE;
        else if (m_mode == M_IDLE && bus.start)     m_mode = M_RUN;
        else if (m_mode == M_IDLE && bus.step)      m_mode = M_STEP;
        else if (m_mode == M_STEP && f)             m_mode = M_IDLE;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("im_cs", bus.im_cs, m_fire());
        check("im_addr", bus.im_addr, m_pc);
        check("instr_valid", bus.instr_valid, m_valid);
        check("busy", bus.busy, (m_mode != M_IDLE) || m_valid);
        check("fetch_count", bus.fetch_count, m_cnt);
        if (bus.instr_valid && bus.instr_ready && !bus.redirect) begin
          if (exp_q.size() == 0) begin
            check("unexpected_instr", 1, 0);
          end else begin
            fetch_t e;
            e = exp_q.pop_front();
            check("instr", bus.instr, e.data);
            check("instr_pc", bus.instr_pc, e.pc);
          end
        end
      end
    end
  end

  task automatic set_in(bit s, bit st, bit h, bit r, int rpc, bit rdy);
    bus.start       = s;
    bus.step        = st;
    bus.halt_req    = h;
    bus.redirect    = r;
    bus.redirect_pc = ADDR_W'(rpc);
    bus.instr_ready = rdy;
  endtask

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_values(string tag);
    check({tag, "_im_cs"}, bus.im_cs, 0);
    check({tag, "_im_addr"}, bus.im_addr, 0);
    check({tag, "_instr"}, bus.instr, 0);
    check({tag, "_instr_pc"}, bus.instr_pc, 0);
    check({tag, "_instr_valid"}, bus.instr_valid, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_fetch_count"}, bus.fetch_count, 0);
  endtask

  initial begin
    int sat_fires;
    mem[0] = 32'h002000B3;
    mem[1] = 32'h11111111;
    mem[2] = 32'h22222222;
    mem[3] = 32'h33333333;
    set_in(0, 0, 0, 0, 0, 0);
    sbus.start = 1'b0; sbus.step = 1'b0; sbus.halt_req = 1'b0;
    sbus.redirect = 1'b0; sbus.redirect_pc = '0; sbus.instr_ready = 1'b0;

    #1 reset = 1'b1;
    #1 check_reset_values("reset");
    @(posedge clk); #1 reset = 1'b0;

    // Free run with wrap: six fetches from address 0 leave pc at 2.
    set_in(1, 0, 0, 0, 0, 1); tick();
    set_in(0, 0, 0, 0, 0, 1); tick(6);
    set_in(0, 0, 1, 0, 0, 1); tick();

    set_in(0, 1, 0, 0, 0, 1); tick();
    set_in(0, 0, 0, 0, 0, 1); tick(2);
    check("step1_instr_pc", bus.instr_pc, 2);
    check("step1_count", bus.fetch_count, 7);
    set_in(0, 1, 0, 0, 0, 1); tick();
    set_in(0, 0, 0, 0, 0, 1); tick(2);
    check("step2_instr_pc", bus.instr_pc, 3);
    check("step2_count", bus.fetch_count, 8);

    // Stall for three cycles after the first capture.
    set_in(1, 0, 0, 0, 0, 1); tick();
    set_in(0, 0, 0, 0, 0, 0); tick(4);
    check("stall_instr_pc", bus.instr_pc, 0);
    set_in(0, 0, 0, 0, 0, 1); tick(3);

    // Redirect while stalled.
    set_in(0, 0, 0, 0, 0, 0); tick();
    set_in(0, 0, 0, 1, 1, 0); tick();
    set_in(0, 0, 0, 0, 0, 0); tick();
    check("redirect_instr_pc", bus.instr_pc, 1);
    set_in(0, 0, 0, 0, 0, 1); tick(2);

    // Halt with a held instruction.
    set_in(0, 0, 0, 0, 0, 0); tick();
    set_in(0, 0, 1, 0, 0, 0); tick();
    set_in(0, 0, 0, 0, 0, 0); tick();
    check("halt_busy_held", bus.busy, 1);
    check("halt_valid_held", bus.instr_valid, 1);
    set_in(0, 0, 0, 0, 0, 1); tick();
    check("halt_busy_drained", bus.busy, 0);
    tick(2);

    // Asynchronous reset in the middle of a run.
    set_in(1, 0, 0, 0, 0, 1); tick();
    set_in(0, 0, 0, 0, 0, 1); tick(2);
    #2 reset = 1'b1;
    #1 check_reset_values("midreset");
    @(posedge clk); #1 reset = 1'b0;

    // Randomized traffic against the model.
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    for (int i = 0; i < 3000; i++) begin
      set_in(($urandom % 8) == 0, ($urandom % 8) == 0, ($urandom % 16) == 0,
             ($urandom % 16) == 0, int'($urandom_range(DEPTH - 1, 0)),
             ($urandom % 4) != 0);
      tick();
    end
    set_in(0, 0, 1, 0, 0, 1); tick(2);

    // Saturation on the narrow-counter instance.
    sat_fires = 12;
    sbus.instr_ready = 1'b1;
    sbus.start = 1'b1; tick();
    sbus.start = 1'b0; tick(sat_fires);
    sbus.halt_req = 1'b1; tick();
    sbus.halt_req = 1'b0; tick();
    check("sat_count", sbus.fetch_count, (sat_fires > 7) ? 7 : sat_fires);
    check("sat_idle_cs", sbus.im_cs, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
